// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Stall and flush vectors are indexed by pipeline register.
package pipe_ctrl_pkg;

  localparam int unsigned PC_W = 32;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  localparam int unsigned IDX_PC     = 0;
  localparam int unsigned IDX_IF_ID  = 1;
  localparam int unsigned IDX_ID_EX  = 2;
  localparam int unsigned IDX_EX_MEM = 3;
  localparam int unsigned IDX_MEM_WB = 4;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DMISS_WAIT  = 3'd1,
    ST_MULDIV_BUSY = 3'd2,
    ST_IMISS_WAIT  = 3'd3,
    ST_REDIRECT    = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_cnt.sv
// Mul/div occupancy countdown: loads on start, then decrements every cycle
// and saturates at zero.
module muldiv_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 6
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: priority decode of
// cache misses, mul/div, mispredicts and load-use, plus fetch redirect.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            IMISS,
  input  logic            IFILL_DONE,
  input  logic            DMISS,
  input  logic            DFILL_DONE,
  input  logic            LOAD_USE,
  input  logic            MULDIV_START,
  input  logic            BR_MISPREDICT,
  input  logic [PC_W-1:0] BR_TARGET,
  output logic            STALL_PC,
  output logic            STALL_IF_ID,
  output logic            STALL_ID_EX,
  output logic            STALL_EX_MEM,
  output logic            FLUSH_IF_ID,
  output logic            FLUSH_ID_EX,
  output logic            FLUSH_EX_MEM,
  output logic            FLUSH_MEM_WB,
  output logic            REDIRECT_VALID,
  output logic [PC_W-1:0] REDIRECT_PC,
  output logic [31:0]     STALL_CYCLES
);

  // The start cycle is spent in IDLE and the zero-count cycle in MULDIV_BUSY.
  localparam logic [CNT_W-1:0] MULDIV_LOAD = CNT_W'(MULDIV_LAT - 2);

  state_t                 state;
  state_t                 state_nxt;
  logic                   cnt_load;
  logic                   cnt_zero;
  logic [CNT_W-1:0]       cnt;
  logic                   redir_take;
  logic [IDX_EX_MEM:0]    stall;
  logic [IDX_MEM_WB:0]    flush;

  muldiv_cnt #(.CNT_W(CNT_W)) u_cnt (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (cnt_load),
    .load_val (MULDIV_LOAD),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_load   = 1'b0;
    redir_take = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // A mul/div entering EX is counted even when a D-miss wins priority.
        cnt_load = MULDIV_START;
        if (DMISS) begin
          state_nxt = ST_DMISS_WAIT;
        end else if (MULDIV_START) begin
          state_nxt = ST_MULDIV_BUSY;
        end else if (BR_MISPREDICT) begin
          state_nxt  = ST_REDIRECT;
          redir_take = 1'b1;
        end else if (IMISS && !LOAD_USE) begin
          state_nxt = ST_IMISS_WAIT;
        end
      end
      ST_DMISS_WAIT: begin
        if (DFILL_DONE) begin
          state_nxt = cnt_zero ? ST_IDLE : ST_MULDIV_BUSY;
        end
      end
      ST_MULDIV_BUSY: begin
        if (cnt_zero) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IMISS_WAIT: begin
        if (DMISS) begin
          state_nxt = ST_DMISS_WAIT;
        end else if (BR_MISPREDICT) begin
          state_nxt  = ST_REDIRECT;
          redir_take = 1'b1;
        end else if (IFILL_DONE) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_REDIRECT: state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    stall = '0;
    flush = '0;
    unique case (state)
      ST_IDLE: begin
        if (DMISS) begin
          stall = '1;
          flush[IDX_MEM_WB] = 1'b1;
        end else if (MULDIV_START) begin
          stall[IDX_PC]     = 1'b1;
          stall[IDX_IF_ID]  = 1'b1;
          stall[IDX_ID_EX]  = 1'b1;
          flush[IDX_EX_MEM] = 1'b1;
        end else if (BR_MISPREDICT) begin
          flush[IDX_IF_ID] = 1'b1;
          flush[IDX_ID_EX] = 1'b1;
        end else if (LOAD_USE) begin
          stall[IDX_PC]    = 1'b1;
          stall[IDX_IF_ID] = 1'b1;
          flush[IDX_ID_EX] = 1'b1;
        end else if (IMISS) begin
          stall[IDX_PC]    = 1'b1;
          flush[IDX_IF_ID] = 1'b1;
        end
      end
      ST_DMISS_WAIT: begin
        // On fill completion the load leaves MEM; a still-running mul/div
        // keeps EX frozen and feeds bubbles into EX/MEM.
        if (!DFILL_DONE) begin
          stall = '1;
          flush[IDX_MEM_WB] = 1'b1;
        end else if (!cnt_zero) begin
          stall[IDX_PC]     = 1'b1;
          stall[IDX_IF_ID]  = 1'b1;
          stall[IDX_ID_EX]  = 1'b1;
          flush[IDX_EX_MEM] = 1'b1;
        end
      end
      ST_MULDIV_BUSY: begin
        stall[IDX_PC]     = 1'b1;
        stall[IDX_IF_ID]  = 1'b1;
        stall[IDX_ID_EX]  = 1'b1;
        flush[IDX_EX_MEM] = 1'b1;
      end
      ST_IMISS_WAIT: begin
        if (DMISS) begin
          stall = '1;
          flush[IDX_MEM_WB] = 1'b1;
        end else if (BR_MISPREDICT) begin
          flush[IDX_IF_ID] = 1'b1;
          flush[IDX_ID_EX] = 1'b1;
        end else begin
          stall[IDX_PC] = 1'b1;
          if (LOAD_USE) begin
            stall[IDX_IF_ID] = 1'b1;
            flush[IDX_ID_EX] = 1'b1;
          end else begin
            flush[IDX_IF_ID] = 1'b1;
          end
        end
      end
      ST_REDIRECT: flush[IDX_IF_ID] = 1'b1;
      default: begin
        stall = '0;
        flush = '0;
      end
    endcase
    if (!RESET) begin
      stall = '0;
      flush = '0;
    end
  end

  assign STALL_PC     = stall[IDX_PC];
  assign STALL_IF_ID  = stall[IDX_IF_ID];
  assign STALL_ID_EX  = stall[IDX_ID_EX];
  assign STALL_EX_MEM = stall[IDX_EX_MEM];
  assign FLUSH_IF_ID  = flush[IDX_IF_ID];
  assign FLUSH_ID_EX  = flush[IDX_ID_EX];
  assign FLUSH_EX_MEM = flush[IDX_EX_MEM];
  assign FLUSH_MEM_WB = flush[IDX_MEM_WB];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      REDIRECT_VALID <= 1'b0;
      REDIRECT_PC    <= RESET_PC;
    end else begin
      REDIRECT_VALID <= redir_take;
      if (redir_take) begin
        REDIRECT_PC <= BR_TARGET;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      STALL_CYCLES <= '0;
    end else if (STALL_PC) begin
      STALL_CYCLES <= STALL_CYCLES + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: IDLE priority decode table plus
// multi-cycle sequences on two instances (MULDIV_LAT 32 and 8).
module tb_pipe_hazard_ctrl;

  logic        CLK;
  logic        RESET;
  logic        IMISS, IFILL_DONE, DMISS, DFILL_DONE, LOAD_USE, MULDIV_START, BR_MISPREDICT;
  logic [31:0] BR_TARGET;

  logic        a_spc, a_sifid, a_sidex, a_sexmem, a_fifid, a_fidex, a_fexmem, a_fmemwb;
  logic        a_rv;
  logic [31:0] a_rpc, a_cyc;
  logic        b_spc, b_sifid, b_sidex, b_sexmem, b_fifid, b_fidex, b_fexmem, b_fmemwb;
  logic        b_rv;
  logic [31:0] b_rpc, b_cyc;

  logic [7:0] ov32, ov8;
  assign ov32 = {a_spc, a_sifid, a_sidex, a_sexmem, a_fifid, a_fidex, a_fexmem, a_fmemwb};
  assign ov8  = {b_spc, b_sifid, b_sidex, b_sexmem, b_fifid, b_fidex, b_fexmem, b_fmemwb};

  pipe_hazard_ctrl #(.MULDIV_LAT(32), .CNT_W(6)) u_dut32 (
    .CLK(CLK), .RESET(RESET), .IMISS(IMISS), .IFILL_DONE(IFILL_DONE),
    .DMISS(DMISS), .DFILL_DONE(DFILL_DONE), .LOAD_USE(LOAD_USE),
    .MULDIV_START(MULDIV_START), .BR_MISPREDICT(BR_MISPREDICT), .BR_TARGET(BR_TARGET),
    .STALL_PC(a_spc), .STALL_IF_ID(a_sifid), .STALL_ID_EX(a_sidex), .STALL_EX_MEM(a_sexmem),
    .FLUSH_IF_ID(a_fifid), .FLUSH_ID_EX(a_fidex), .FLUSH_EX_MEM(a_fexmem), .FLUSH_MEM_WB(a_fmemwb),
    .REDIRECT_VALID(a_rv), .REDIRECT_PC(a_rpc), .STALL_CYCLES(a_cyc)
  );

  pipe_hazard_ctrl #(.MULDIV_LAT(8), .CNT_W(6)) u_dut8 (
    .CLK(CLK), .RESET(RESET), .IMISS(IMISS), .IFILL_DONE(IFILL_DONE),
    .DMISS(DMISS), .DFILL_DONE(DFILL_DONE), .LOAD_USE(LOAD_USE),
    .MULDIV_START(MULDIV_START), .BR_MISPREDICT(BR_MISPREDICT), .BR_TARGET(BR_TARGET),
    .STALL_PC(b_spc), .STALL_IF_ID(b_sifid), .STALL_ID_EX(b_sidex), .STALL_EX_MEM(b_sexmem),
    .FLUSH_IF_ID(b_fifid), .FLUSH_ID_EX(b_fidex), .FLUSH_EX_MEM(b_fexmem), .FLUSH_MEM_WB(b_fmemwb),
    .REDIRECT_VALID(b_rv), .REDIRECT_PC(b_rpc), .STALL_CYCLES(b_cyc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Output vector: {STALL PC,IF_ID,ID_EX,EX_MEM, FLUSH IF_ID,ID_EX,EX_MEM,MEM_WB}
  localparam logic [7:0] OV_NONE = 8'h00;
  localparam logic [7:0] OV_DMISS = 8'hF1;
  localparam logic [7:0] OV_MUL = 8'hE2;
  localparam logic [7:0] OV_BR = 8'h0C;
  localparam logic [7:0] OV_LU = 8'hC4;
  localparam logic [7:0] OV_IMISS = 8'h88;
  localparam logic [7:0] OV_REDIR = 8'h08;

  typedef struct {
    string      name;
    logic [4:0] in;   // {DMISS, MULDIV_START, BR_MISPREDICT, LOAD_USE, IMISS}
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];
  int   total;
  int   bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_in();
    IMISS = 0; IFILL_DONE = 0; DMISS = 0; DFILL_DONE = 0;
    LOAD_USE = 0; MULDIV_START = 0; BR_MISPREDICT = 0;
  endtask

  task automatic do_reset();
    RESET = 0;
    #1;
    RESET = 1;
  endtask

  logic [39:0] obs32, obs8;
  logic [7:0]  fexp[8];

  initial begin
    total = 0;
    bad = 0;
    vecs[0] = '{"idle_none",    5'b00000, OV_NONE};
    vecs[1] = '{"dmiss",        5'b10000, OV_DMISS};
    vecs[2] = '{"muldiv",       5'b01000, OV_MUL};
    vecs[3] = '{"mispredict",   5'b00100, OV_BR};
    vecs[4] = '{"load_use",     5'b00010, OV_LU};
    vecs[5] = '{"imiss",        5'b00001, OV_IMISS};
    vecs[6] = '{"pri_all",      5'b11111, OV_DMISS};
    vecs[7] = '{"pri_mul",      5'b01111, OV_MUL};
    vecs[8] = '{"pri_br",       5'b00111, OV_BR};
    vecs[9] = '{"pri_lu_imiss", 5'b00011, OV_LU};
    fexp = '{OV_DMISS, OV_DMISS, OV_DMISS, OV_DMISS, OV_MUL, OV_MUL, OV_MUL, OV_NONE};

    // Held in reset with requests active: everything must stay quiet.
    RESET = 0;
    BR_TARGET = 32'h0;
    clr_in();
    DMISS = 1; MULDIV_START = 1; IMISS = 1;
    #2;
    chk("in_reset_out32", 64'(ov32), 64'(OV_NONE));
    chk("in_reset_out8", 64'(ov8), 64'(OV_NONE));
    clr_in();
    cyc();
    RESET = 1;
    #1;
    chk("rst_rv", 64'(a_rv), 64'd0);
    chk("rst_rpc", 64'(a_rpc), 64'd0);
    chk("rst_cycles", 64'(a_cyc), 64'd0);
    chk("rst_rv8", 64'(b_rv), 64'd0);
    chk("rst_rpc8", 64'(b_rpc), 64'd0);
    chk("rst_cycles8", 64'(b_cyc), 64'd0);

    // IDLE priority decode table.
    foreach (vecs[i]) begin
      cyc();
      do_reset();
      {DMISS, MULDIV_START, BR_MISPREDICT, LOAD_USE, IMISS} = vecs[i].in;
      #1;
      chk(vecs[i].name, 64'(ov32), 64'(vecs[i].exp));
      chk({vecs[i].name, "_l8"}, 64'(ov8), 64'(vecs[i].exp));
      clr_in();
    end

    // Single mul/div: stall window is exactly MULDIV_LAT cycles.
    cyc();
    do_reset();
    MULDIV_START = 1;
    #1;
    obs32 = '0;
    obs8 = '0;
    obs32[0] = a_sidex & a_fexmem;
    obs8[0]  = b_sidex & b_fexmem;
    for (int i = 1; i < 40; i++) begin
      cyc();
      MULDIV_START = 0;
      #1;
      obs32[i] = a_sidex & a_fexmem;
      obs8[i]  = b_sidex & b_fexmem;
    end
    chk("muldiv32_window", 64'(obs32), 64'h00_FFFF_FFFF);
    chk("muldiv8_window", 64'(obs8), 64'h00_0000_00FF);
    chk("muldiv32_cycles", 64'(a_cyc), 64'd32);
    chk("muldiv8_cycles", 64'(b_cyc), 64'd8);

    // Mispredict from IDLE: flush, then one-cycle redirect.
    cyc();
    BR_MISPREDICT = 1;
    BR_TARGET = 32'h0000_0400;
    #1;
    chk("br_c0_out", 64'(ov32), 64'(OV_BR));
    chk("br_c0_rv", 64'(a_rv), 64'd0);
    cyc();
    BR_MISPREDICT = 0;
    BR_TARGET = 32'hDEAD_BEEF;
    #1;
    chk("br_c1_out", 64'(ov32), 64'(OV_REDIR));
    chk("br_c1_rv", 64'(a_rv), 64'd1);
    chk("br_c1_rpc", 64'(a_rpc), 64'h400);
    chk("br_c1_rpc8", 64'(b_rpc), 64'h400);
    cyc();
    #1;
    chk("br_c2_out", 64'(ov32), 64'(OV_NONE));
    chk("br_c2_rv", 64'(a_rv), 64'd0);
    chk("br_c2_rv8", 64'(b_rv), 64'd0);

    // Reset asserted while MULDIV_BUSY with the counter at 10.
    cyc();
    MULDIV_START = 1;
    for (int k = 1; k <= 21; k++) begin
      cyc();
      MULDIV_START = 0;
    end
    chk("busy_pre_reset", 64'(ov32), 64'(OV_MUL));
    RESET = 0;
    #1;
    chk("async_rst_out", 64'(ov32), 64'(OV_NONE));
    chk("async_rst_rv", 64'(a_rv), 64'd0);
    chk("async_rst_rpc", 64'(a_rpc), 64'd0);
    chk("async_rst_cycles", 64'(a_cyc), 64'd0);
    RESET = 1;
    cyc();
    #1;
    chk("post_rst_idle", 64'(ov32), 64'(OV_NONE));
    chk("post_rst_cycles", 64'(a_cyc), 64'd0);
    // A cleared counter makes a D-fill return straight to IDLE.
    cyc();
    DMISS = 1;
    cyc();
    DMISS = 0;
    DFILL_DONE = 1;
    #1;
    chk("post_rst_dfill", 64'(ov32), 64'(OV_NONE));
    cyc();
    DFILL_DONE = 0;
    #1;
    chk("post_rst_after_fill", 64'(ov32), 64'(OV_NONE));

    // LOAD_USE held two cycles: stateless bubble insertion.
    cyc();
    LOAD_USE = 1;
    #1;
    chk("lu_c0", 64'(ov32), 64'(OV_LU));
    cyc();
    #1;
    chk("lu_c1", 64'(ov32), 64'(OV_LU));
    cyc();
    LOAD_USE = 0;
    #1;
    chk("lu_c2", 64'(ov32), 64'(OV_NONE));

    // DMISS and MULDIV_START together on the LAT=8 instance, fill 5 cycles on.
    cyc();
    do_reset();
    DMISS = 1;
    MULDIV_START = 1;
    #1;
    chk("dm_mul_start", 64'(ov8), 64'(OV_DMISS));
    for (int c = 0; c < 8; c++) begin
      cyc();
      MULDIV_START = 0;
      DMISS = (c < 4);
      DFILL_DONE = (c == 4);
      #1;
      chk($sformatf("dm_mul_c%0d", c), 64'(ov8), 64'(fexp[c]));
    end
    DFILL_DONE = 0;

    // IMISS wait abandoned by a mispredict; late IFILL_DONE is harmless.
    cyc();
    do_reset();
    IMISS = 1;
    #1;
    chk("im_c0", 64'(ov32), 64'(OV_IMISS));
    cyc();
    #1;
    chk("im_c1", 64'(ov32), 64'(OV_IMISS));
    cyc();
    LOAD_USE = 1;
    #1;
    chk("im_c2_lu", 64'(ov32), 64'(OV_LU));
    cyc();
    LOAD_USE = 0;
    BR_MISPREDICT = 1;
    BR_TARGET = 32'h1234_5678;
    #1;
    chk("im_c3_br", 64'(ov32), 64'(OV_BR));
    cyc();
    BR_MISPREDICT = 0;
    IMISS = 0;
    #1;
    chk("im_c4_out", 64'(ov32), 64'(OV_REDIR));
    chk("im_c4_rv", 64'(a_rv), 64'd1);
    chk("im_c4_rpc", 64'(a_rpc), 64'h1234_5678);
    cyc();
    IFILL_DONE = 1;
    #1;
    chk("im_c5_out", 64'(ov32), 64'(OV_NONE));
    chk("im_c5_rv", 64'(a_rv), 64'd0);
    cyc();
    IFILL_DONE = 0;
    #1;
    chk("im_c6_out", 64'(ov32), 64'(OV_NONE));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
